// File: rtl/uart_word_assembler_pkg.sv
// Shared types and error codes for the UART receive-side word assembler.
package uart_word_assembler_pkg;

  typedef enum logic {
    S_HI = 1'b0,
    S_LO = 1'b1
  } asm_state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_RXERR   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

endpackage

// File: rtl/uart_word_assembler_rise_det.sv
// Registered rising-edge detector: rise is high the cycle after din goes 0 -> 1.
module uart_word_assembler_rise_det (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic prev_q, prev_d;
  logic rise_q, rise_d;

  always_comb begin
    prev_d = din;
    rise_d = din & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/uart_word_assembler.sv
// Rebuilds 16-bit words (MSB byte first) from uart_receiver byte events and
// presents them on a valid/ready register; discarded pairs raise err_pulse.
module uart_word_assembler
  import uart_word_assembler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int WORD_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_ferror,
  input  logic              rx_perror,
  output logic              rx_en,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              err_pulse,
  output logic [1:0]        err_code
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic valid_rise, ferr_rise, perr_rise;

  uart_word_assembler_rise_det u_valid_det (.clk(clk), .reset(reset), .din(rx_valid),  .rise(valid_rise));
  uart_word_assembler_rise_det u_ferr_det  (.clk(clk), .reset(reset), .din(rx_ferror), .rise(ferr_rise));
  uart_word_assembler_rise_det u_perr_det  (.clk(clk), .reset(reset), .din(rx_perror), .rise(perr_rise));

  asm_state_t        state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [7:0]        data_q, data_d;
  logic [7:0]        hi_q, hi_d;
  logic [WORD_W-1:0] word_data_q, word_data_d;
  logic              word_valid_q, word_valid_d;
  logic              err_pulse_q, err_pulse_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              rx_en_q, rx_en_d;

  logic err_ev, byte_ev, complete;

  // Byte is aligned with the registered edge so the FSM sees the byte that rose.
  assign err_ev  = ferr_rise | perr_rise;
  assign byte_ev = valid_rise & ~err_ev;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    data_d       = rx_data;
    hi_d         = hi_q;
    word_data_d  = word_data_q;
    word_valid_d = word_valid_q;
    err_pulse_d  = 1'b0;
    err_code_d   = err_code_q;
    rx_en_d      = enable;
    complete     = 1'b0;

    if (word_valid_q && word_ready) word_valid_d = 1'b0;

    if (!enable) begin
      state_d = S_HI;
      timer_d = '0;
      hi_d    = '0;
    end else begin
      unique case (state_q)
        S_HI: begin
          if (err_ev) begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_RXERR;
          end else if (byte_ev) begin
            hi_d    = data_q;
            timer_d = '0;
            state_d = S_LO;
          end
        end
        S_LO: begin
          timer_d = (timer_q == '1) ? timer_q : timer_q + TW'(1);
          if (err_ev) begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_RXERR;
            hi_d        = '0;
            state_d     = S_HI;
          end else if (byte_ev) begin
            complete = 1'b1;
            state_d  = S_HI;
          end else if (timer_q == TIMER_LAST) begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
            hi_d        = '0;
            state_d     = S_HI;
          end
        end
        default: state_d = S_HI;
      endcase
    end

    // A word completing in the same cycle as an accept replaces the accepted one.
    if (complete) begin
      if (!word_valid_q || word_ready) begin
        word_data_d  = {hi_q, data_q};
        word_valid_d = 1'b1;
      end else begin
        err_pulse_d = 1'b1;
        err_code_d  = ERR_OVERRUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_HI;
      timer_q      <= '0;
      data_q       <= '0;
      hi_q         <= '0;
      word_data_q  <= '0;
      word_valid_q <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
      rx_en_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      data_q       <= data_d;
      hi_q         <= hi_d;
      word_data_q  <= word_data_d;
      word_valid_q <= word_valid_d;
      err_pulse_q  <= err_pulse_d;
      err_code_q   <= err_code_d;
      rx_en_q      <= rx_en_d;
    end
  end

  assign rx_en      = rx_en_q;
  assign word_data  = word_data_q;
  assign word_valid = word_valid_q;
  assign err_pulse  = err_pulse_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_uart_word_assembler.sv
// Directed bench for uart_word_assembler: byte events are driven directly as
// the receiver would produce them, with a short timeout for quick runs.
module tb_uart_word_assembler;

  localparam int T = 32;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ferror, rx_perror;
  logic        rx_en;
  logic [15:0] word_data;
  logic        word_valid, word_ready;
  logic        err_pulse;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int pulse_base;

  uart_word_assembler #(.TIMEOUT_CYCLES(T), .WORD_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ferror(rx_ferror), .rx_perror(rx_perror),
    .rx_en(rx_en), .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .err_pulse(err_pulse), .err_code(err_code)
  );

  always #10 clk = ~clk;

  always @(posedge clk) if (err_pulse) pulse_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the FSM has acted.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_ferr();
    rx_ferror = 1'b1;
    @(negedge clk);
    rx_ferror = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; word_ready = 1'b1;
    rx_data = 8'h00; rx_valid = 1'b0; rx_ferror = 1'b0; rx_perror = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rx_en", 32'(rx_en), 32'h0);
    chk("rst_word_valid", 32'(word_valid), 32'h0);
    chk("rst_word_data", 32'(word_data), 32'h0);
    chk("rst_err_pulse", 32'(err_pulse), 32'h0);
    chk("rst_err_code", 32'(err_code), 32'h0);
    reset = 1'b0; enable = 1'b1;
    @(negedge clk);
    chk("rx_en_follows", 32'(rx_en), 32'h1);

    // 1: back-to-back pair
    send_byte(8'hA5);
    chk("t1_no_valid_after_hi", 32'(word_valid), 32'h0);
    send_byte(8'hC3);
    chk("t1_valid", 32'(word_valid), 32'h1);
    chk("t1_data", 32'(word_data), 32'hA5C3);
    @(negedge clk);
    chk("t1_handshake_clear", 32'(word_valid), 32'h0);
    chk("t1_no_err", 32'(pulse_cnt), 32'h0);

    // 2: timeout exactly T cycles after the high byte is taken
    send_byte(8'h12);
    repeat (T - 1) @(negedge clk);
    chk("t2_no_early_timeout", 32'(err_pulse), 32'h0);
    @(negedge clk);
    chk("t2_timeout_pulse", 32'(err_pulse), 32'h1);
    chk("t2_timeout_code", 32'(err_code), 32'h2);
    @(negedge clk);
    chk("t2_pulse_one_cycle", 32'(err_pulse), 32'h0);
    send_byte(8'h34);
    send_byte(8'h56);
    chk("t2_next_valid", 32'(word_valid), 32'h1);
    chk("t2_next_data", 32'(word_data), 32'h3456);
    @(negedge clk);

    // 3: framing error mid-pair, then data+parity rising together in S_HI
    send_byte(8'h77);
    send_ferr();
    chk("t3_ferr_pulse", 32'(err_pulse), 32'h1);
    chk("t3_ferr_code", 32'(err_code), 32'h1);
    chk("t3_no_valid", 32'(word_valid), 32'h0);
    rx_data = 8'h99; rx_valid = 1'b1; rx_perror = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; rx_perror = 1'b0;
    @(negedge clk);
    chk("t3_simul_pulse", 32'(err_pulse), 32'h1);
    chk("t3_simul_code", 32'(err_code), 32'h1);
    send_byte(8'hAB);
    send_byte(8'hCD);
    chk("t3_pair_after_err", 32'(word_data), 32'hABCD);
    @(negedge clk);

    // 4: overrun, then accept coinciding with completion
    word_ready = 1'b0;
    send_byte(8'h11);
    send_byte(8'h11);
    chk("t4_first_valid", 32'(word_valid), 32'h1);
    send_byte(8'h22);
    send_byte(8'h22);
    chk("t4_overrun_pulse", 32'(err_pulse), 32'h1);
    chk("t4_overrun_code", 32'(err_code), 32'h3);
    chk("t4_kept_data", 32'(word_data), 32'h1111);
    chk("t4_kept_valid", 32'(word_valid), 32'h1);
    word_ready = 1'b1;
    @(negedge clk);
    chk("t4_handshake_clear", 32'(word_valid), 32'h0);
    word_ready = 1'b0;
    send_byte(8'h33);
    send_byte(8'h44);
    chk("t4_held_data", 32'(word_data), 32'h3344);
    send_byte(8'h55);
    rx_data = 8'h66; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; word_ready = 1'b1;
    @(negedge clk);
    chk("t4_simul_valid", 32'(word_valid), 32'h1);
    chk("t4_simul_data", 32'(word_data), 32'h5566);
    chk("t4_simul_no_pulse", 32'(err_pulse), 32'h0);
    @(negedge clk);
    chk("t4_simul_clear", 32'(word_valid), 32'h0);

    // 5: reset mid-word with a pending word
    word_ready = 1'b0;
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'hFF);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_rx_en", 32'(rx_en), 32'h0);
    chk("t5_valid", 32'(word_valid), 32'h0);
    chk("t5_data", 32'(word_data), 32'h0);
    chk("t5_code", 32'(err_code), 32'h0);
    @(negedge clk);
    word_ready = 1'b1;
    send_byte(8'h0F);
    send_byte(8'hF0);
    chk("t5_new_word", 32'(word_data), 32'h0FF0);
    @(negedge clk);

    // 6: enable drop discards high byte silently
    pulse_base = pulse_cnt;
    send_byte(8'hAA);
    enable = 1'b0;
    @(negedge clk);
    chk("t6_rx_en_low", 32'(rx_en), 32'h0);
    enable = 1'b1;
    @(negedge clk);
    send_byte(8'hBB);
    send_byte(8'hCC);
    chk("t6_valid", 32'(word_valid), 32'h1);
    chk("t6_data", 32'(word_data), 32'hBBCC);
    @(negedge clk);
    @(negedge clk);
    chk("t6_no_err", 32'(pulse_cnt - pulse_base), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
